// File: rtl/alu_issue.sv
// alu_issue: issue stage between regfile read and execute.
// Decodes one RV32I instruction per handshake into the alu operand/control
// fields and holds them in a single output pipeline register.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   flush                       kill the held entry and reject this cycle's input
//   in_valid / in_ready         input handshake for instr, pc, rs1_val, rs2_val
//   instr, pc, rs1_val, rs2_val instruction word, its address, regfile reads
//   out_valid / out_ready       output handshake towards execute
//   op, op_imm                  R-type / I-type ALU class flags
//   funct3, funct7              alu operation select and modifier
//   a, b                        alu operands
//   rd                          destination register index (0 for stores)
//   illegal                     entry carries an illegal encoding
module alu_issue #(
  parameter int unsigned XLEN        = 32,  // only 32 is supported
  parameter bit          CHK_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            op,
  output logic            op_imm,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [2:0] F3Add = 3'b000;
  localparam logic [2:0] F3Sl  = 3'b001;
  localparam logic [2:0] F3Sr  = 3'b101;

  localparam logic [6:0] F7Alt = 7'h20;

  logic [6:0]      opcode;
  logic [2:0]      f3_raw;
  logic [6:0]      f7_raw;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;

  logic            dec_op, dec_op_imm, dec_ill;
  logic [2:0]      dec_f3;
  logic [6:0]      dec_f7;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [4:0]      dec_rd;
  logic            load;

  assign opcode = instr[6:0];
  assign f3_raw = instr[14:12];
  assign f7_raw = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  // A held entry that execute will not take blocks new input; reset blocks too.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    dec_op     = 1'b0;
    dec_op_imm = 1'b0;
    dec_f3     = F3Add;
    dec_f7     = 7'h00;
    dec_a      = '0;
    dec_b      = '0;
    dec_rd     = instr[11:7];
    dec_ill    = 1'b0;
    unique case (opcode)
      OpcOp: begin
        dec_op = 1'b1;
        dec_a  = rs1_val;
        dec_b  = rs2_val;
        dec_f3 = f3_raw;
        dec_f7 = f7_raw;
        if (f7_raw != 7'h00 && f7_raw != F7Alt) dec_ill = 1'b1;
        if (f7_raw == F7Alt && f3_raw != F3Add && f3_raw != F3Sr) dec_ill = 1'b1;
      end
      OpcOpImm: begin
        dec_op_imm = 1'b1;
        dec_a      = rs1_val;
        dec_f3     = f3_raw;
        if (f3_raw == F3Sl || f3_raw == F3Sr) begin
          dec_b  = shamt;
          dec_f7 = f7_raw;
          if (f3_raw == F3Sl && f7_raw != 7'h00) dec_ill = 1'b1;
          if (f3_raw == F3Sr && f7_raw != 7'h00 && f7_raw != F7Alt) dec_ill = 1'b1;
        end else begin
          // Upper immediate bits are part of the constant, not a modifier.
          dec_b = imm_i;
        end
      end
      OpcLoad: begin
        dec_a = rs1_val;
        dec_b = imm_i;
      end
      OpcStore: begin
        dec_a  = rs1_val;
        dec_b  = imm_s;
        dec_rd = 5'd0;  // instr[11:7] is immediate, not a destination
      end
      OpcLui: begin
        dec_b = imm_u;
      end
      OpcAuipc: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      op        <= 1'b0;
      op_imm    <= 1'b0;
      funct3    <= '0;
      funct7    <= '0;
      a         <= '0;
      b         <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      // Kill only; data fields keep their last values.
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      op        <= dec_op;
      op_imm    <= dec_op_imm;
      funct3    <= dec_f3;
      funct7    <= dec_f7;
      a         <= dec_a;
      b         <= dec_b;
      rd        <= dec_rd;
      illegal   <= CHK_ILLEGAL ? dec_ill : 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  typedef struct packed {
    logic        op;
    logic        op_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_val, rs2_val;
  logic        op, op_imm, illegal;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] a, b;
  logic [4:0]  rd;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  alu_issue #(.XLEN(32), .CHK_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .op_imm(op_imm), .funct3(funct3), .funct7(funct7),
    .a(a), .b(b), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic o, logic oi, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] ea, logic [31:0] eb, logic [4:0] erd,
                              logic ill);
    exp_t e;
    e = '{op: o, op_imm: oi, f3: f3, f7: f7, a: ea, b: eb, rd: erd, ill: ill};
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e = '{op: op, op_imm: op_imm, f3: funct3, f7: funct7, a: a, b: b, rd: rd, ill: illegal};
    return e;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Present one instruction and hold it until accepted; expectation is queued
  // just before the accepting edge.
  task automatic send(logic [31:0] i, logic [31:0] p, logic [31:0] r1, logic [31:0] r2,
                      exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    #2;
    instr = i; pc = p; rs1_val = r1; rs2_val = r2; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr %h never accepted", i);
    end else begin
      q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: samples 1 time unit before each rising edge, when all inputs for
  // that edge are settled and registered outputs are stable.
  exp_t snap;
  logic stall_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_hold", actual(), snap);
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
        if (out_valid && out_ready && !flush) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h want none", actual());
          end else begin
            chk("scoreboard", actual(), q.pop_front());
          end
        end
        stall_prev = out_valid && !out_ready && !flush;
        snap = actual();
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;
    #1;
    chk("reset_outputs", {out_valid, in_ready, actual()}, '0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed decode vectors, back to back
    send(32'hFFF10093, 0, 5, 0, mk(0, 1, 0, 0, 5, 32'hFFFFFFFF, 1, 0));          // ADDI
    send(32'h402081B3, 0, 20, 7, mk(1, 0, 0, 7'h20, 20, 7, 3, 0));               // SUB
    send(32'h40435293, 0, 32'hFFFFFF9C, 0,
         mk(0, 1, 5, 7'h20, 32'hFFFFFF9C, 4, 5, 0));                             // SRAI
    send(32'h123453B7, 0, 9, 9, mk(0, 0, 0, 0, 0, 32'h12345000, 7, 0));          // LUI
    send(32'hFFFFFFFF, 0, 9, 9, mk(0, 0, 0, 0, 0, 0, 5'h1F, 1));                 // bad opcode
    send(32'h00001097, 32'h80000000, 9, 9,
         mk(0, 0, 0, 0, 32'h80000000, 32'h1000, 1, 0));                          // AUIPC
    idle();
    drain();

    // Stream of 4 with a 3-cycle back-pressure window mid-stream
    fork
      begin
        send(32'hFFF10093, 0, 11, 0, mk(0, 1, 0, 0, 11, 32'hFFFFFFFF, 1, 0));
        send(32'h402081B3, 0, 100, 1, mk(1, 0, 0, 7'h20, 100, 1, 3, 0));
        send(32'h40435293, 0, 32'h80, 0, mk(0, 1, 5, 7'h20, 32'h80, 4, 5, 0));
        send(32'h123453B7, 0, 0, 0, mk(0, 0, 0, 0, 0, 32'h12345000, 7, 0));
        idle();
      end
      begin
        repeat (2) @(negedge clk);
        #2;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with a held entry and a competing input: entry killed, no load
    @(negedge clk);
    #2;
    out_ready = 1'b0;
    send(32'h00001097, 32'h1000, 0, 0, mk(0, 0, 0, 0, 32'h1000, 32'h1000, 1, 0));
    idle();
    @(negedge clk);
    #2;
    flush = 1'b1; out_ready = 1'b1;
    instr = 32'hFF81A203; rs1_val = 32'h40; in_valid = 1'b1;
    @(negedge clk);
    #2;
    flush = 1'b0; in_valid = 1'b0;
    void'(q.pop_front());  // the killed entry
    #1;
    chk("flush_kills", out_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("flush_no_load", out_valid, 1'b0);

    // Asynchronous reset while an entry is held
    @(negedge clk);
    #2;
    out_ready = 1'b0;
    send(32'h40001033, 0, 9, 3, mk(1, 0, 1, 7'h20, 9, 3, 0, 1));
    idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_midstream", {out_valid, in_ready, actual()}, '0);
    q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;

    // Remaining decode cases after reset
    send(32'h40001033, 0, 9, 3, mk(1, 0, 1, 7'h20, 9, 3, 0, 1));                 // SUB-form SLL
    send(32'h00512423, 0, 32'h100, 5, mk(0, 0, 0, 0, 32'h100, 8, 0, 0));         // SW +8
    send(32'hFE512E23, 0, 32'h100, 5, mk(0, 0, 0, 0, 32'h100, 32'hFFFFFFFC, 0, 0)); // SW -4
    send(32'hFF81A203, 0, 32'h40, 0, mk(0, 0, 0, 0, 32'h40, 32'hFFFFFFF8, 4, 0)); // LW -8
    send(32'h02009093, 0, 6, 0, mk(0, 1, 1, 7'h01, 6, 0, 1, 1));                 // SLLI f7=1
    send(32'h4000F093, 0, 6, 0, mk(0, 1, 7, 0, 6, 32'h400, 1, 0));               // ANDI 0x400
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
